// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared FP16 field widths, constants, flag struct and helpers
package fp16_pkg;

  localparam int FP16_SIGN_W  = 1;
  localparam int FP16_EXP_W   = 5;
  localparam int FP16_FRAC_W  = 10;
  localparam int FP16_W       = FP16_SIGN_W + FP16_EXP_W + FP16_FRAC_W;
  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_MAX = 2 * FP16_BIAS + 1;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;

  typedef struct packed {
    logic nan;
    logic overflow;
    logic inexact;
  } fp16_flags_t;

  typedef enum logic {ST_IDLE, ST_ACC} acc_state_t;

  // Leading-zero count of a 15-bit word; 15 when the word is zero.
  function automatic logic [3:0] lzc15(input logic [14:0] v);
    lzc15 = 4'd15;
    for (int i = 0; i < 15; i++) begin
      if (v[i]) lzc15 = 4'(14 - i);
    end
  endfunction

endpackage

// File: rtl/fp16_dot_accum_if.sv
// rtl/fp16_dot_accum_if.sv - product stream in, burst result FIFO out
interface fp16_dot_accum_if #(parameter int CNT_W = 8);

  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_last;
  logic             in_overflow;
  logic             in_nan;
  logic             in_precision_lost;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_nan;
  logic             out_overflow;
  logic             out_inexact;
  logic             drop_err;

  modport master (
    output in_valid, in_data, in_last, in_overflow, in_nan, in_precision_lost, out_ready,
    input  out_valid, out_sum, out_count, out_nan, out_overflow, out_inexact, drop_err
  );

  modport slave (
    input  in_valid, in_data, in_last, in_overflow, in_nan, in_precision_lost, out_ready,
    output out_valid, out_sum, out_count, out_nan, out_overflow, out_inexact, drop_err
  );

endinterface

// File: rtl/fp16_add_comb.sv
// rtl/fp16_add_comb.sv - combinational FP16 adder with FTZ and round-to-nearest-even
module fp16_add_comb
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic [FP16_W-1:0] sum,
  output logic              nan,
  output logic              overflow,
  output logic              inexact
);

  localparam logic signed [6:0] EXP_MAX_S = 7'(FP16_EXP_MAX);

  logic                   sa, sb;
  logic [FP16_EXP_W-1:0]  ea, eb;
  logic [FP16_FRAC_W-1:0] fa, fb;
  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  // Exponent 0 is flushed to a signed zero; infinities and NaNs sit at exponent 31.
  logic a_sub, b_sub, a_nan, b_nan, a_inf, b_inf;
  assign a_sub = (ea == '0);
  assign b_sub = (eb == '0);
  assign a_nan = (ea == '1) && (fa != '0);
  assign b_nan = (eb == '1) && (fb != '0);
  assign a_inf = (ea == '1) && (fa == '0);
  assign b_inf = (eb == '1) && (fb == '0);

  // Significands carry hidden bit at [13] and guard/round/sticky at [2:0].
  logic [13:0] ma, mb;
  assign ma = a_sub ? 14'b0 : {1'b1, fa, 3'b000};
  assign mb = b_sub ? 14'b0 : {1'b1, fb, 3'b000};

  logic a_big;
  assign a_big = ({ea, fa} & {15{~a_sub}}) >= ({eb, fb} & {15{~b_sub}});

  logic                  big_s;
  logic [FP16_EXP_W-1:0] big_e, d;
  logic [13:0]           big_m, small_m, aligned;
  assign big_s   = a_big ? sa : sb;
  assign big_e   = a_big ? ea : eb;
  assign d       = a_big ? (ea - eb) : (eb - ea);
  assign big_m   = a_big ? ma : mb;
  assign small_m = a_big ? mb : ma;
  // Bits shifted past the sticky position collapse into bit 0.
  assign aligned = (small_m >> d) | {13'b0, |(small_m & ~(14'h3FFF << d))};

  logic [14:0] sum_raw, shl;
  logic [3:0]  lz;
  logic        carry;
  assign sum_raw = (sa ^ sb) ? ({1'b0, big_m} - {1'b0, aligned})
                             : ({1'b0, big_m} + {1'b0, aligned});
  assign lz      = lzc15(sum_raw);
  assign carry   = sum_raw[14];
  assign shl     = sum_raw << (lz - 4'd1);

  logic [13:0]        norm;
  logic signed [6:0]  e_res, e_fin;
  assign norm  = carry ? {sum_raw[14:2], sum_raw[1] | sum_raw[0]} : shl[13:0];
  assign e_res = carry ? ($signed({2'b00, big_e}) + 7'sd1)
                       : ($signed({2'b00, big_e}) - $signed({3'b000, lz}) + 7'sd1);

  logic        g_bit, rest, rnd_up;
  logic [11:0] mant;
  assign g_bit  = norm[2];
  assign rest   = norm[1] | norm[0];
  assign rnd_up = g_bit & (rest | norm[3]);
  assign mant   = {1'b0, norm[13:3]} + {11'b0, rnd_up};
  assign e_fin  = e_res + (mant[11] ? 7'sd1 : 7'sd0);

  // Special operands first, then exact zero, then the rounded finite result.
  always_comb begin
    sum      = '0;
    nan      = 1'b0;
    overflow = 1'b0;
    inexact  = (a_sub & (fa != '0)) | (b_sub & (fb != '0));
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      sum = FP16_QNAN;
      nan = 1'b1;
    end else if (a_inf) begin
      sum = {sa, FP16_PINF[14:0]};
    end else if (b_inf) begin
      sum = {sb, FP16_PINF[14:0]};
    end else if (sum_raw == '0) begin
      sum = {sa & sb, 15'b0};
    end else begin
      inexact = inexact | g_bit | rest;
      if (e_fin >= EXP_MAX_S) begin
        sum      = {big_s, FP16_PINF[14:0]};
        overflow = 1'b1;
      end else if (e_fin <= 7'sd0) begin
        sum     = {big_s, 15'b0};
        inexact = 1'b1;
      end else begin
        sum = {big_s, e_fin[4:0], mant[11] ? mant[10:1] : mant[9:0]};
      end
    end
  end

endmodule

// File: rtl/fp16_dot_accum.sv
// rtl/fp16_dot_accum.sv - per-burst FP16 accumulator with 2-entry result FIFO
module fp16_dot_accum
  import fp16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rstn,
  fp16_dot_accum_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [FP16_W-1:0] sum;
    logic [CNT_W-1:0]  count;
    fp16_flags_t       flags;
  } fifo_entry_t;

  acc_state_t        state;
  logic [FP16_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  fp16_flags_t       acc_flags;

  // In IDLE the adder sees +0, so the first beat loads through the same FTZ/NaN rules.
  logic [FP16_W-1:0] add_sum;
  logic              add_nan, add_ovf, add_inexact;
  fp16_add_comb u_add (
    .a        (state == ST_IDLE ? '0 : acc),
    .b        (bus.in_data),
    .sum      (add_sum),
    .nan      (add_nan),
    .overflow (add_ovf),
    .inexact  (add_inexact)
  );

  logic [CNT_W-1:0] cnt_next;
  fp16_flags_t      flags_next;
  assign cnt_next = (state == ST_IDLE) ? CNT_W'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
  assign flags_next.nan      = acc_flags.nan      | bus.in_nan            | add_nan;
  assign flags_next.overflow = acc_flags.overflow | bus.in_overflow       | add_ovf;
  assign flags_next.inexact  = acc_flags.inexact  | bus.in_precision_lost | add_inexact;

  // Burst FSM: hold the partial sum until the last beat, then clear for the next burst.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      acc_flags <= '0;
    end else if (bus.in_valid) begin
      if (bus.in_last) begin
        state     <= ST_IDLE;
        acc       <= '0;
        cnt       <= '0;
        acc_flags <= '0;
      end else begin
        state     <= ST_ACC;
        acc       <= add_sum;
        cnt       <= cnt_next;
        acc_flags <= flags_next;
      end
    end
  end

  fifo_entry_t mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  occ;
  logic        push_req, push, pop, full;
  fifo_entry_t head;

  assign full     = (occ == 2'd2);
  assign pop      = (occ != 2'd0) & bus.out_ready;
  assign push_req = bus.in_valid & bus.in_last;
  // A full FIFO still accepts a result when its head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign head     = mem[rd_ptr];

  // Result FIFO storage, pointers, occupancy and sticky drop indication.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem[0]       <= '0;
      mem[1]       <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      occ          <= 2'd0;
      bus.drop_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{sum: add_sum, count: cnt_next, flags: flags_next};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (push_req && !push) bus.drop_err <= 1'b1;
    end
  end

  assign bus.out_valid    = (occ != 2'd0);
  assign bus.out_sum      = bus.out_valid ? head.sum : '0;
  assign bus.out_count    = bus.out_valid ? head.count : '0;
  assign bus.out_nan      = bus.out_valid & head.flags.nan;
  assign bus.out_overflow = bus.out_valid & head.flags.overflow;
  assign bus.out_inexact  = bus.out_valid & head.flags.inexact;

endmodule

// File: tb/tb_fp16_dot_accum.sv
// tb/tb_fp16_dot_accum.sv - directed self-checking bench for fp16_dot_accum
module tb_fp16_dot_accum;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_err = 0;

  fp16_dot_accum_if #(.CNT_W(8)) bus ();

  fp16_dot_accum #(.CNT_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last,
                      input logic nan_f = 1'b0, input logic ovf_f = 1'b0, input logic pl_f = 1'b0);
    bus.in_valid          = 1'b1;
    bus.in_data           = d;
    bus.in_last           = last;
    bus.in_nan            = nan_f;
    bus.in_overflow       = ovf_f;
    bus.in_precision_lost = pl_f;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_nan   = 1'b0;
    bus.in_overflow = 1'b0;
    bus.in_precision_lost = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] s, input int cnt,
                           input logic nan_e, input logic ovf_e, input logic inx_e);
    @(negedge clk);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".sum"}, 32'(bus.out_sum), 32'(s));
    check({tag, ".count"}, 32'(bus.out_count), 32'(cnt));
    check({tag, ".nan"}, 32'(bus.out_nan), 32'(nan_e));
    check({tag, ".ovf"}, 32'(bus.out_overflow), 32'(ovf_e));
    check({tag, ".inexact"}, 32'(bus.out_inexact), 32'(inx_e));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.in_nan = 1'b0; bus.in_overflow = 1'b0; bus.in_precision_lost = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.sum", 32'(bus.out_sum), 32'd0);
    check("rst.count", 32'(bus.out_count), 32'd0);
    check("rst.flags", 32'({bus.out_nan, bus.out_overflow, bus.out_inexact}), 32'd0);
    check("rst.drop", 32'(bus.drop_err), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // 1+1+1+1 = 4; no result visible while the last beat is still being presented
    for (int i = 0; i < 3; i++) send(16'h3C00, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 16'h3C00; bus.in_last = 1'b1;
    @(negedge clk);
    check("sum4.pre_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    pop_check("sum4", 16'h4400, 4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("sum4.empty", 32'(bus.out_valid), 32'd0);

    // back-to-back bursts: cancellation to +0, then overflow to +inf
    send(16'h3C00, 1'b0); send(16'hBC00, 1'b1);
    send(16'h7BFF, 1'b0); send(16'h7BFF, 1'b1);
    pop_check("cancel", 16'h0000, 2, 1'b0, 1'b0, 1'b0);
    pop_check("ovf", 16'h7C00, 2, 1'b0, 1'b1, 1'b0);

    // 1 + 2^-11 is a tie that rounds to even (1.0)
    send(16'h3C00, 1'b0); send(16'h1000, 1'b1);
    pop_check("tie", 16'h3C00, 2, 1'b0, 1'b0, 1'b1);
    send(16'h4000, 1'b1);
    pop_check("single", 16'h4000, 1, 1'b0, 1'b0, 1'b0);

    // inf + -inf and an upstream NaN flag
    send(16'h7C00, 1'b0); send(16'hFC00, 1'b1);
    pop_check("inf_inf", 16'h7E00, 2, 1'b1, 1'b0, 1'b0);
    send(16'h3C00, 1'b1, 1'b1);
    pop_check("in_nan", 16'h3C00, 1, 1'b1, 1'b0, 1'b0);

    // counter saturates at 255
    for (int i = 0; i < 299; i++) send(16'h0000, 1'b0);
    send(16'h0000, 1'b1);
    pop_check("sat", 16'h0000, 255, 1'b0, 1'b0, 1'b0);

    // full FIFO with a simultaneous pop still accepts the new result
    send(16'h3C00, 1'b1); send(16'h4000, 1'b1);
    bus.out_ready = 1'b1;
    send(16'h4400, 1'b1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("fullpop.drop", 32'(bus.drop_err), 32'd0);
    pop_check("fullpop.h0", 16'h4000, 1, 1'b0, 1'b0, 1'b0);
    pop_check("fullpop.h1", 16'h4400, 1, 1'b0, 1'b0, 1'b0);

    // full FIFO without pop drops the third result
    send(16'h3C00, 1'b1); send(16'h4000, 1'b1); send(16'h4200, 1'b1);
    @(negedge clk);
    check("drop.flag", 32'(bus.drop_err), 32'd1);
    pop_check("drop.h0", 16'h3C00, 1, 1'b0, 1'b0, 1'b0);
    pop_check("drop.h1", 16'h4000, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("drop.empty", 32'(bus.out_valid), 32'd0);

    // reset mid-burst, with a last beat presented during reset
    send(16'h4000, 1'b0); send(16'h4000, 1'b0);
    rstn = 1'b0;
    send(16'h4200, 1'b1);
    rstn = 1'b1;
    @(negedge clk);
    check("rst2.valid", 32'(bus.out_valid), 32'd0);
    check("rst2.drop", 32'(bus.drop_err), 32'd0);
    send(16'h4000, 1'b1);
    pop_check("rst2", 16'h4000, 1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fp16_dot_accum.md
# fp16_dot_accum

Streaming FP16 accumulator that sits directly downstream of the pipelined FP16 multiplier. It consumes one product per cycle together with the multiplier's flags and sums each burst, delimited by `in_last`, into one FP16 dot-product result. The per-burst result goes into a 2-entry output FIFO that has a valid/ready handshake. The upstream multiplier has no backpressure, so this block accepts a beat on every cycle in which `in_valid` is high.

## Interface
- `CNT_W`, default 8: width of the per-burst element counter. The counter saturates.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `in_valid` in 1: product beat valid (driven by the multiplier's `valid_out`).
- `in_data` in 16: FP16 product.
- `in_last` in 1: this beat closes the burst.
- `in_overflow`, `in_nan`, `in_precision_lost` in 1 each: multiplier flags for the beat.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_sum` out 16: accumulated FP16 sum.
- `out_count` out CNT_W: number of beats in the burst.
- `out_nan`, `out_overflow`, `out_inexact` out 1 each: sticky flags for the burst.
- `drop_err` out 1: sticky flag. Set when a burst result was lost because the FIFO was full. Cleared only by reset.

## Operation
- Two-state FSM.
  - IDLE: accumulator empty.
  - ACC: partial sum held in `acc`.
- Beat in IDLE: the operand is +0 + `in_data`, so `acc` loads the beat value after the FTZ/NaN rules below are applied.
- Beat in ACC: `acc <= acc + in_data` using the single-cycle adder.
- Any beat with `in_last=1`:
  - The sum (acc + beat) is pushed to the FIFO together with the count and flags.
  - The FSM goes to IDLE and all per-burst state is cleared.
  - A last beat arriving in IDLE gives a 1-element burst.
- Counter:
  - Set to 1 on the first beat, then incremented by 1 per beat.
  - Saturates at 2^CNT_W-1.
- Sticky burst flags are OR-accumulated per burst:
  - nan |= in_nan | adder NaN.
  - overflow |= in_overflow | adder overflow.
  - inexact |= in_precision_lost | adder inexact.
- Adder arithmetic:
  - Inputs: exponent 0 is flushed to ±0 (FTZ). A flush with nonzero fraction sets inexact.
  - Working width: 11-bit significand (hidden bit included) plus guard, round and sticky bits.
  - The smaller operand is aligned right with sticky; then add or subtract.
  - Normalize with a leading-zero count.
  - Round to nearest even. Any discarded nonzero bit sets inexact.
  - Result exponent ≤0: flush to ±0 and set inexact.
  - Result exponent ≥31: ±inf (sign|0x7C00) and set overflow.
  - Exact zero sum: +0, except (-0)+(-0) = -0.
  - NaN operand: output 0x7E00, NaN flag set.
  - inf + -inf: output 0x7E00, NaN flag set.
  - inf + finite: that inf.
- FIFO:
  - 2 entries. Each entry is {sum, count, nan, overflow, inexact}.
  - Pop happens when `out_valid & out_ready`.
  - Push when full and no pop in the same cycle: the new result is discarded, `drop_err` is set to 1, and the FIFO contents are unchanged.
  - Push when full with a pop in the same cycle: accepted.

## Timing
- Reset values:
  - `out_valid=0`, `out_sum=0`, `out_count=0`, all flags 0, `drop_err=0`.
  - FSM in IDLE, FIFO empty.
- Reset mid-burst: the partial sum is discarded. A beat presented during a reset cycle is ignored.
- Latency: the last beat in cycle N gives `out_valid=1` in cycle N+1 if the FIFO was empty.
- Throughput: one beat per cycle with no bubbles. Back-to-back bursts are allowed, e.g. a last beat followed immediately by the first beat of the next burst.
- `out_*` hold stable while `out_valid & ~out_ready`.
- Push and pop in the same cycle on a 1-entry FIFO: occupancy stays 1 and the head advances.

## Structure
- Shared package `fp16_pkg`:
  - FP16 field widths (1/5/10) and exponent bias 15.
  - Constants `FP16_QNAN=16'h7E00`, `FP16_PINF=16'h7C00`.
  - Flag struct typedef.
- One sub-module, `fp16_add_comb`: a combinational FP16 adder implementing the rules above, with outputs sum, nan, overflow and inexact.
- The FSM, counter and FIFO live in the top level.

## Test plan
- 4 beats of 0x3C00, last on beat 4, `out_ready=1` → `out_sum=0x4400`, `out_count=4`, all flags 0, `out_valid` one cycle after the last beat.
- 0x3C00 then 0xBC00 (last) → `out_sum=0x0000`. Then 0x7BFF, 0x7BFF (last) → `out_sum=0x7C00`, `out_overflow=1`.
- 0x3C00 then 0x1000 (last), a tie case → `out_sum=0x3C00`, `out_inexact=1`. A single beat 0x4000 with last → `0x4000`, count 1.
- 0x7C00 then 0xFC00 (last) → `0x7E00`, `out_nan=1`. A beat with `in_nan=1` and data 0x3C00 → `out_nan=1`.
- `out_ready=0`, three 1-beat bursts 0x3C00/0x4000/0x4200 → FIFO holds 0x3C00 and 0x4000, `drop_err=1`. After popping with `out_ready=1`, 0x3C00 then 0x4000 are returned.
- Reset asserted after 2 beats of a burst, then a new burst 0x4000 (last) → `out_sum=0x4000`, `out_count=1`, no stale data.
